restore_div_sequencer: RTL

//  Sequences the 8-bit restoring divider (restore) through its enable opcodes so no client drives them by hand.
//  A client hands in dividend/divisor on a valid/ready request; the block runs init, load M, load Q, run and readout.
//  It returns quotient/remainder on a valid/ready response; divide-by-zero is trapped without touching the divider.

---
 rtl/restore_div_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/restore_div_sequencer.sv
// Request/response front end for one 8-bit restoring divider (restore).
// Drives the divider's enable opcodes and inbus through init, operand load,
// run and readout, and traps divide-by-zero without touching the divider.
module restore_div_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RUN_CYCLES = 8,
  parameter int unsigned RD_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic [WIDTH-1:0] div_inbus,
  output logic [2:0]       div_enable,
  input  logic [WIDTH-1:0] div_outbus
);

  localparam int unsigned CNT_MAX = (RUN_CYCLES > RD_CYCLES) ? RUN_CYCLES : RD_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] RUN_LOAD = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD  = CW'(RD_CYCLES - 1);

  localparam logic [2:0] OP_INIT = 3'b001;
  localparam logic [2:0] OP_LDM  = 3'b011;
  localparam logic [2:0] OP_LDQ  = 3'b010;
  localparam logic [2:0] OP_RUN  = 3'b100;
  localparam logic [2:0] OP_RDA  = 3'b101;
  localparam logic [2:0] OP_RDQ  = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LOAD_M,
    S_LOAD_Q,
    S_RUN,
    S_RD_A,
    S_RD_Q,
    S_ZERO,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [2:0]       enable_q, enable_d;
  logic [WIDTH-1:0] inbus_q, inbus_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  // Next-state, datapath update, and output values decoded from the next state
  // so every output is a register that matches the state it is in.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          state_d    = (divisor == '0) ? S_ZERO : S_INIT;
        end
      end
      S_INIT:   state_d = S_LOAD_M;
      S_LOAD_M: state_d = S_LOAD_Q;
      S_LOAD_Q: begin
        state_d = S_RUN;
        cnt_d   = RUN_LOAD;
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_RD_A;
          cnt_d   = RD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_A: begin
        if (cnt_q == '0) begin
          rem_d   = div_outbus;
          state_d = S_RD_Q;
          cnt_d   = RD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_Q: begin
        if (cnt_q == '0) begin
          quot_d  = div_outbus;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ZERO: begin
        quot_d  = '1;
        rem_d   = dividend_q;
        dbz_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_INIT:   enable_d = OP_INIT;
      S_LOAD_M: enable_d = OP_LDM;
      S_LOAD_Q: enable_d = OP_LDQ;
      S_RUN:    enable_d = OP_RUN;
      S_RD_A:   enable_d = OP_RDA;
      S_RD_Q:   enable_d = OP_RDQ;
      default:  enable_d = OP_HOLD;
    endcase

    inbus_d = '0;
    if (state_d == S_LOAD_M) inbus_d = divisor_d;
    if (state_d == S_LOAD_Q) inbus_d = dividend_d;

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // State, operand/result and registered-output storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      enable_q    <= OP_HOLD;
      inbus_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      enable_q    <= enable_d;
      inbus_q     <= inbus_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign div_inbus   = inbus_q;
  assign div_enable  = enable_q;

endmodule
